// File: rtl/urv_arb_pkg.sv
// Shared types for the uRV fetch/data RAM arbiter.
// Grant and state encodings travel down the return pipeline.
package urv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_FETCH = 2'd0,
        GNT_LOAD  = 2'd1,
        GNT_STORE = 2'd2
    } grant_t;

    // Done strobes are exactly one cycle; this is their register width.
    localparam int unsigned DONE_PULSE_W = 1;

    // Wide enough for the largest legal MAX_DATA_BURST (15).
    localparam int unsigned BURST_CNT_W = 4;

endpackage

// File: rtl/urv_mem_arbiter_if.sv
// CPU-side and RAM-side signal bundle of the fetch/data RAM arbiter.
// slave = arbiter view, master = CPU plus RAM environment view.
interface urv_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 14
);
    logic [31:0]           im_addr_i;
    logic [31:0]           im_data_o;
    logic                  im_valid_o;

    logic [31:0]           dm_addr_i;
    logic [31:0]           dm_data_s_i;
    logic [3:0]            dm_data_select_i;
    logic                  dm_load_i;
    logic                  dm_store_i;
    logic [31:0]           dm_data_l_o;
    logic                  dm_load_done_o;
    logic                  dm_store_done_o;
    logic                  dm_ready_o;

    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [31:0]           ram_wdata_o;
    logic [3:0]            ram_we_o;
    logic [31:0]           ram_rdata_i;

    modport slave (
        input  im_addr_i, dm_addr_i, dm_data_s_i, dm_data_select_i,
               dm_load_i, dm_store_i, ram_rdata_i,
        output im_data_o, im_valid_o, dm_data_l_o, dm_load_done_o,
               dm_store_done_o, dm_ready_o, ram_addr_o, ram_wdata_o, ram_we_o
    );

    modport master (
        output im_addr_i, dm_addr_i, dm_data_s_i, dm_data_select_i,
               dm_load_i, dm_store_i, ram_rdata_i,
        input  im_data_o, im_valid_o, dm_data_l_o, dm_load_done_o,
               dm_store_done_o, dm_ready_o, ram_addr_o, ram_wdata_o, ram_we_o
    );

endinterface

// File: rtl/urv_arb_burst_cnt.sv
// Saturating count of consecutive data grants; at_max forces a fetch slot.
// Zero latency on o_at_max; no backpressure, updates every cycle.
module urv_arb_burst_cnt
    import urv_arb_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam logic [BURST_CNT_W-1:0] LP_MAX = BURST_CNT_W'(MAX);

    logic [BURST_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == LP_MAX);

endmodule

// File: rtl/urv_mem_arbiter.sv
// Shares one sync-read RAM between uRV fetch and data ports; fetch/load 2 cycles, store done next cycle.
// Data requests are held until their done pulse; fetch takes every slot data does not.
module urv_mem_arbiter
    import urv_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    urv_mem_arbiter_if.slave bus
);

    state_t                  r_state;
    logic                    r_ready;
    logic                    r_s1_vld;
    grant_t                  r_s1_gnt;
    logic [ADDR_WIDTH-1:0]   r_fa_q;
    logic [31:0]             r_im_data;
    logic                    r_im_valid;
    logic [31:0]             r_dm_data_l;
    logic [DONE_PULSE_W-1:0] r_ld_done;
    logic [DONE_PULSE_W-1:0] r_st_done;

    grant_t                  w_gnt;
    logic                    w_data_req;
    logic                    w_data_gnt;
    logic                    w_at_max;
    logic [ADDR_WIDTH-1:0]   w_im_word;
    logic [ADDR_WIDTH-1:0]   w_dm_word;
    logic                    w_unused_bits;

    assign w_im_word = bus.im_addr_i[ADDR_WIDTH+1:2];
    assign w_dm_word = bus.dm_addr_i[ADDR_WIDTH+1:2];

    // Byte offset and address bits above the RAM wrap are don't-care.
    assign w_unused_bits = ^{bus.im_addr_i[31:ADDR_WIDTH+2], bus.im_addr_i[1:0],
                             bus.dm_addr_i[31:ADDR_WIDTH+2], bus.dm_addr_i[1:0]};

    // A store wins over a simultaneous (illegal) load.
    always_comb begin
        w_data_req = bus.dm_load_i | bus.dm_store_i;
        w_data_gnt = w_data_req && (r_state == IDLE) && !w_at_max;
        w_gnt      = GNT_FETCH;
        if (w_data_gnt) begin
            w_gnt = bus.dm_store_i ? GNT_STORE : GNT_LOAD;
        end
    end

    urv_arb_burst_cnt #(
        .MAX (MAX_DATA_BURST)
    ) u_burst_cnt (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_inc    (w_data_gnt),
        .i_clr    (!w_data_gnt),
        .o_at_max (w_at_max)
    );

    // RAM port is quiet while reset is held.
    assign bus.ram_addr_o  = !rst_n_i ? '0
                           : (w_gnt == GNT_FETCH) ? w_im_word : w_dm_word;
    assign bus.ram_we_o    = (rst_n_i && (w_gnt == GNT_STORE)) ? bus.dm_data_select_i : 4'h0;
    assign bus.ram_wdata_o = (rst_n_i && (w_gnt == GNT_STORE)) ? bus.dm_data_s_i : 32'h0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gnt == GNT_STORE) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b0;
                    end else if (w_gnt == GNT_LOAD) begin
                        r_state <= LD_WAIT;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                LD_WAIT: begin
                    r_state <= ST_DONE;
                    r_ready <= 1'b0;
                end
                ST_DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stage 1 remembers what was issued; stage 2 captures the RAM word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_vld    <= 1'b0;
            r_s1_gnt    <= GNT_FETCH;
            r_fa_q      <= '0;
            r_im_data   <= '0;
            r_im_valid  <= 1'b0;
            r_dm_data_l <= '0;
            r_ld_done   <= '0;
            r_st_done   <= '0;
        end else begin
            r_s1_vld  <= 1'b1;
            r_s1_gnt  <= w_gnt;
            r_st_done <= {DONE_PULSE_W{w_gnt == GNT_STORE}};
            if (w_gnt == GNT_FETCH) begin
                r_fa_q <= w_im_word;
            end

            // A PC change between issue and capture makes the word stale.
            if (r_s1_vld && (r_s1_gnt == GNT_FETCH)) begin
                r_im_data  <= bus.ram_rdata_i;
                r_im_valid <= (r_fa_q == w_im_word);
            end else begin
                r_im_valid <= 1'b0;
            end

            if (r_s1_vld && (r_s1_gnt == GNT_LOAD)) begin
                r_dm_data_l <= bus.ram_rdata_i;
                r_ld_done   <= '1;
            end else begin
                r_ld_done   <= '0;
            end
        end
    end

    assign bus.im_data_o       = r_im_data;
    assign bus.im_valid_o      = r_im_valid;
    assign bus.dm_data_l_o     = r_dm_data_l;
    assign bus.dm_load_done_o  = |r_ld_done;
    assign bus.dm_store_done_o = |r_st_done;
    assign bus.dm_ready_o      = r_ready;

    a_no_dual_req: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                    !(bus.dm_load_i && bus.dm_store_i));

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Randomized bench for urv_mem_arbiter against a cycle-indexed transaction model.
module tb_urv_mem_arbiter;

    localparam int unsigned AW   = 14;
    localparam int unsigned MAXB = 2;
    localparam int unsigned NW   = 1 << AW;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    urv_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    urv_mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .MAX_DATA_BURST (MAXB)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    // RAM the arbiter drives, and the model's own view of memory.
    logic [31:0] ram     [NW];
    logic [31:0] ref_mem [NW];
    logic [31:0] env_w;

    always @(posedge clk_i) begin
        env_w = ram[bus.ram_addr_o];
        for (int b = 0; b < 4; b++)
            if (bus.ram_we_o[b]) env_w[8*b +: 8] = bus.ram_wdata_o[8*b +: 8];
        if (|bus.ram_we_o) ram[bus.ram_addr_o] <= env_w;
        bus.ram_rdata_i <= ram[bus.ram_addr_o];
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          c_first = 0;
    int          m_free = 0;
    int unsigned m_consec = 0;
    int          g_last = 0;
    logic        e_imv [4];
    logic        e_ldv [4];
    logic        e_std [4];
    logic [31:0] e_imd [4];
    logic [31:0] e_ldd [4];
    logic        pf_vld = 1'b0;
    int unsigned pf_word = 0;
    logic [31:0] pf_data = 32'h0;
    logic [31:0] last_ld = 32'h0;
    logic        saw_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % NW;
    endfunction

    // Check this cycle's outputs, then decide who owns the RAM this cycle.
    task automatic check_and_model();
        int          s;
        int unsigned w;
        logic [31:0] v;
        bit          exp_free;
        bit          exp_rdy;
        s        = cyc % 4;
        exp_free = (cyc >= m_free);
        exp_rdy  = exp_free && (cyc != c_first);

        chk("im_valid", 32'(bus.im_valid_o), 32'(e_imv[s]));
        if (e_imv[s]) chk("im_data", bus.im_data_o, e_imd[s]);
        chk("ld_done", 32'(bus.dm_load_done_o), 32'(e_ldv[s]));
        if (e_ldv[s]) chk("ld_data", bus.dm_data_l_o, e_ldd[s]);
        chk("st_done", 32'(bus.dm_store_done_o), 32'(e_std[s]));
        chk("ready", 32'(bus.dm_ready_o), 32'(exp_rdy));
        e_imv[s] = 1'b0;
        e_ldv[s] = 1'b0;
        e_std[s] = 1'b0;

        if (bus.dm_load_done_o) last_ld = bus.dm_data_l_o;
        saw_done = bus.dm_load_done_o | bus.dm_store_done_o;

        if (pf_vld) begin
            e_imv[(cyc + 1) % 4] = (pf_word == widx(bus.im_addr_i));
            e_imd[(cyc + 1) % 4] = pf_data;
        end
        pf_vld = 1'b0;

        if ((bus.dm_load_i || bus.dm_store_i) && exp_free && (m_consec < MAXB)) begin
            w = widx(bus.dm_addr_i);
            m_consec++;
            chk("data_addr", 32'(bus.ram_addr_o), 32'(w));
            if (bus.dm_store_i) begin
                v = ref_mem[w];
                for (int b = 0; b < 4; b++)
                    if (bus.dm_data_select_i[b]) v[8*b +: 8] = bus.dm_data_s_i[8*b +: 8];
                chk("st_we", 32'(bus.ram_we_o), 32'(bus.dm_data_select_i));
                chk("st_wdata", bus.ram_wdata_o, bus.dm_data_s_i);
                ref_mem[w] = v;
                e_std[(cyc + 1) % 4] = 1'b1;
                m_free = cyc + 2;
                g_last = 2;
            end else begin
                chk("ld_we", 32'(bus.ram_we_o), 32'd0);
                e_ldv[(cyc + 2) % 4] = 1'b1;
                e_ldd[(cyc + 2) % 4] = ref_mem[w];
                m_free = cyc + 3;
                g_last = 1;
            end
        end else begin
            m_consec = 0;
            pf_vld   = 1'b1;
            pf_word  = widx(bus.im_addr_i);
            pf_data  = ref_mem[pf_word];
            chk("f_we", 32'(bus.ram_we_o), 32'd0);
            chk("f_addr", 32'(bus.ram_addr_o), 32'(pf_word));
            g_last = 0;
        end
    endtask

    // One clock: check at the falling edge, CPU reacts just after the rising edge.
    task automatic tick();
        @(negedge clk_i);
        check_and_model();
        @(posedge clk_i);
        #1;
        cyc++;
        if (saw_done) begin
            bus.dm_load_i  = 1'b0;
            bus.dm_store_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n_i        = 1'b0;
        bus.dm_load_i  = 1'b0;
        bus.dm_store_i = 1'b0;
        bus.im_addr_i  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rst_im_valid", 32'(bus.im_valid_o), 32'd0);
            chk("rst_im_data", bus.im_data_o, 32'd0);
            chk("rst_ld_done", 32'(bus.dm_load_done_o), 32'd0);
            chk("rst_ld_data", bus.dm_data_l_o, 32'd0);
            chk("rst_st_done", 32'(bus.dm_store_done_o), 32'd0);
            chk("rst_ready", 32'(bus.dm_ready_o), 32'd0);
            chk("rst_ram_we", 32'(bus.ram_we_o), 32'd0);
            chk("rst_ram_addr", 32'(bus.ram_addr_o), 32'd0);
            chk("rst_ram_wdata", bus.ram_wdata_o, 32'd0);
            @(posedge clk_i);
            #1;
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            e_imv[i] = 1'b0;
            e_ldv[i] = 1'b0;
            e_std[i] = 1'b0;
        end
        pf_vld   = 1'b0;
        m_consec = 0;
        saw_done = 1'b0;
        rst_n_i  = 1'b1;
        c_first  = cyc;
        m_free   = cyc;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        bus.dm_addr_i        = a;
        bus.dm_data_s_i      = d;
        bus.dm_data_select_i = sel;
        bus.dm_store_i       = 1'b1;
        for (int i = 0; i < 20 && bus.dm_store_i; i++) tick();
        chk("st_timeout", 32'(bus.dm_store_i), 32'd0);
        bus.dm_store_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a);
        bus.dm_addr_i = a;
        bus.dm_load_i = 1'b1;
        last_ld       = 32'h0;
        for (int i = 0; i < 20 && bus.dm_load_i; i++) tick();
        chk("ld_timeout", 32'(bus.dm_load_i), 32'd0);
        bus.dm_load_i = 1'b0;
    endtask

    function automatic logic [31:0] rnd_daddr();
        return ($urandom & 32'hFFFF_0000) | (32'h100 + 4 * $urandom_range(0, 15))
               | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rnd_iaddr();
        return ($urandom & 32'hFFFF_0000) | (4 * $urandom_range(0, 15));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NW; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        for (int i = 0; i < 4; i++) begin
            e_imv[i] = 1'b0;
            e_ldv[i] = 1'b0;
            e_std[i] = 1'b0;
            e_imd[i] = 32'h0;
            e_ldd[i] = 32'h0;
        end
        bus.im_addr_i        = 32'h0;
        bus.dm_addr_i        = 32'h0;
        bus.dm_data_s_i      = 32'h0;
        bus.dm_data_select_i = 4'h0;
        bus.dm_load_i        = 1'b0;
        bus.dm_store_i       = 1'b0;

        do_reset();
        repeat (4) tick();

        do_store(32'h100, 32'hDEADBEEF, 4'b1111);
        do_load(32'h100);
        chk("ld_beef", last_ld, 32'hDEADBEEF);

        do_store(32'h104, 32'h11223344, 4'b1111);
        do_store(32'h104, 32'h000000AA, 4'b0001);
        do_load(32'h104);
        chk("ld_byte", last_ld, 32'h112233AA);

        bus.im_addr_i = 32'h10;
        tick();
        bus.im_addr_i = 32'h40;
        tick();
        bus.im_addr_i = 32'h10;
        repeat (4) tick();

        for (int i = 0; i < 8; i++) do_store(rnd_daddr(), $urandom, 4'hF);

        for (int i = 0; i < 3000; i++) begin
            if (!bus.dm_load_i && !bus.dm_store_i && ($urandom_range(0, 2) == 0)) begin
                bus.dm_addr_i = rnd_daddr();
                if ($urandom_range(0, 1) == 1) begin
                    bus.dm_data_s_i      = $urandom;
                    bus.dm_data_select_i = 4'($urandom_range(1, 15));
                    bus.dm_store_i       = 1'b1;
                end else begin
                    bus.dm_load_i = 1'b1;
                end
            end
            if ($urandom_range(0, 3) == 0) bus.im_addr_i = rnd_iaddr();
            tick();
        end

        for (int i = 0; i < 10 && (bus.dm_load_i || bus.dm_store_i); i++) tick();
        repeat (2) tick();
        bus.dm_addr_i = 32'h100;
        bus.dm_load_i = 1'b1;
        g_last        = 0;
        for (int i = 0; i < 10 && g_last != 1; i++) tick();
        chk("ldwait_ready", 32'(bus.dm_ready_o), 32'd0);
        do_reset();
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
